// File: rtl/ascon_round_ctrl.sv
// Ascon permutation round controller: sequences N rounds through an external
// round datapath. Optional abort port enabled with `define ASCON_CTRL_ABORT_EN.
module ascon_round_ctrl #(
  parameter int unsigned MAX_ROUNDS = 12,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     rounds_i,
  input  logic [4:0][63:0]     state_i,
  input  logic [4:0][63:0]     round_state_i,
  input  logic                 intr_clr_i,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic                 abort_i,
`endif
  output logic [4:0][63:0]     state_o,
  output logic                 round_en_o,
  output logic [CNT_W-1:0]     round_idx_o,
  output logic                 update_state_o,
  output logic                 busy_o,
  output logic                 finished_o,
  output logic                 intr_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ROUNDS);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [4:0][63:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             fin_q, fin_d;
  logic             intr_q, intr_d;
  logic [CNT_W-1:0] eff_rounds;
  logic             abort_w;

`ifdef ASCON_CTRL_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  assign eff_rounds = (rounds_i > MAX_C) ? MAX_C : rounds_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      fin_q   <= 1'b0;
      intr_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fin_q   <= fin_d;
      intr_q  <= intr_d;
    end
  end

  always_comb begin
    fsm_d          = fsm_q;
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    fin_d          = fin_q;
    intr_d         = intr_q;
    round_en_o     = 1'b0;
    update_state_o = 1'b0;
    // Clear first so that a DONE set below overrides a coincident clear.
    if (intr_clr_i) intr_d = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        if (start_i) begin
          state_d = state_i;
          cnt_d   = eff_rounds;
          idx_d   = MAX_C - eff_rounds;
          fin_d   = 1'b0;
          fsm_d   = (eff_rounds == '0) ? DONE : ROUND;
        end
      end
      ROUND: begin
        if (abort_w) begin
          fin_d = 1'b0;
          fsm_d = IDLE;
        end else begin
          round_en_o = 1'b1;
          state_d    = round_state_i;
          idx_d      = idx_q + 1'b1;
          cnt_d      = cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) fsm_d = DONE;
        end
      end
      DONE: begin
        update_state_o = 1'b1;
        fin_d          = 1'b1;
        intr_d         = 1'b1;
        fsm_d          = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign state_o     = state_q;
  assign round_idx_o = idx_q;
  assign busy_o      = (fsm_q != IDLE);
  assign finished_o  = fin_q;
  assign intr_o      = intr_q;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Self-checking bench for ascon_round_ctrl: table vectors, random runs against
// a transaction-level permutation model, and reset/busy/abort sequences.
module tb_ascon_round_ctrl;
  localparam int MAXR = 12;
  typedef logic [4:0][63:0] st_t;

  typedef struct {
    logic [3:0] rounds;
    int         exp_n;
    int         exp_lat;
    int         exp_idx0;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       intr_clr = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] rounds = '0;
  st_t        state_in = '0;
  st_t        round_state;
  st_t        state_out;
  logic       round_en, upd, busy, fin, intr;
  logic [3:0] idx;
  int         n_tests = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  ascon_round_ctrl #(.MAX_ROUNDS(12), .CNT_W(4)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .start_i        (start),
    .rounds_i       (rounds),
    .state_i        (state_in),
    .round_state_i  (round_state),
    .intr_clr_i     (intr_clr),
`ifdef ASCON_CTRL_ABORT_EN
    .abort_i        (abort),
`endif
    .state_o        (state_out),
    .round_en_o     (round_en),
    .round_idx_o    (idx),
    .update_state_o (upd),
    .busy_o         (busy),
    .finished_o     (fin),
    .intr_o         (intr)
  );

  // Stand-in round datapath: any index-dependent mixing function will do.
  function automatic st_t toy_round(input st_t s, input logic [3:0] i);
    st_t r;
    logic [7:0] rc;
    rc = {4'h0, i} * 8'h11 + 8'hF0;
    for (int w = 0; w < 5; w++)
      r[w] = {s[w][62:0], s[w][63]} ^ s[(w + 1) % 5] ^ {56'h0, rc};
    return r;
  endfunction

  always_comb round_state = toy_round(state_out, idx);

  function automatic st_t ref_perm(input st_t s0, input int n);
    st_t s = s0;
    for (int k = MAXR - n; k < MAXR; k++) s = toy_round(s, 4'(k));
    return s;
  endfunction

  function automatic st_t rand_state();
    st_t r;
    for (int w = 0; w < 5; w++) r[w] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_st(input string nm, input st_t act, input st_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input logic [3:0] r, input st_t s0, input bit busy_start,
                         input bit clr_in_done, input string nm, input int exp_n,
                         input int exp_lat, input int exp_idx0);
    int   lat, en_cnt, upd_cnt;
    st_t  exp_s;
    exp_s = ref_perm(s0, exp_n);
    @(negedge clk); intr_clr = 1'b1;
    @(negedge clk); intr_clr = 1'b0;
    chk({nm, " intr cleared"}, intr, 0);
    start = 1'b1; rounds = r; state_in = s0;
    @(negedge clk);
    start = 1'b0; rounds = 4'($urandom); state_in = rand_state();
    chk({nm, " finished cleared"}, fin, 0);
    lat = -1; en_cnt = 0; upd_cnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (round_en) begin
        chk({nm, " round idx"}, idx, exp_idx0 + en_cnt);
        en_cnt++;
      end
      if (upd) begin
        upd_cnt++;
        if (lat < 0) begin
          lat = cyc;
          chk_st({nm, " state at update"}, state_out, exp_s);
        end
      end
      intr_clr = clr_in_done && upd;
      start = busy_start && (cyc == 3);
      if (busy_start && cyc == 3) begin rounds = 4'd0; state_in = rand_state(); end
      if (lat >= 0 && cyc >= lat + 3) break;
      @(negedge clk);
    end
    start = 1'b0; intr_clr = 1'b0;
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " round_en cycles"}, en_cnt, exp_n);
    chk({nm, " update pulses"}, upd_cnt, 1);
    chk({nm, " busy after"}, busy, 0);
    chk({nm, " finished"}, fin, 1);
    chk({nm, " intr"}, intr, 1);
    chk_st({nm, " state held"}, state_out, exp_s);
  endtask

  task automatic start_and_wait_rounds(input logic [3:0] r, input int k, input string nm);
    int en_cnt = 0;
    @(negedge clk); start = 1'b1; rounds = r; state_in = rand_state();
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 30 && en_cnt < k; c++) begin
      if (round_en) en_cnt++;
      if (en_cnt < k) @(negedge clk);
    end
    chk({nm, " reached round"}, en_cnt, k);
  endtask

  task automatic watch_no_update(input string nm);
    int u = 0;
    for (int c = 0; c < 20; c++) begin
      if (upd || round_en) u++;
      @(negedge clk);
    end
    chk({nm, " no update after"}, u, 0);
    chk({nm, " busy"}, busy, 0);
  endtask

  initial begin
    vec_t tbl[6];
    tbl[0] = '{4'd12, 12, 13, 0};
    tbl[1] = '{4'd6,  6,  7,  6};
    tbl[2] = '{4'd0,  0,  1,  12};
    tbl[3] = '{4'd15, 12, 13, 0};
    tbl[4] = '{4'd1,  1,  2,  11};
    tbl[5] = '{4'd13, 12, 13, 0};

    #2;
    chk_st("reset state_o", state_out, '0);
    chk("reset idx", idx, 0);
    chk("reset round_en", round_en, 0);
    chk("reset update", upd, 0);
    chk("reset busy", busy, 0);
    chk("reset finished", fin, 0);
    chk("reset intr", intr, 0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_txn(tbl[i].rounds, rand_state(), 1'b0, 1'b0, $sformatf("vec%0d", i),
              tbl[i].exp_n, tbl[i].exp_lat, tbl[i].exp_idx0);

    for (int i = 0; i < 20; i++) begin
      logic [3:0] r;
      int n;
      r = 4'($urandom_range(0, 15));
      n = (int'(r) > MAXR) ? MAXR : int'(r);
      run_txn(r, rand_state(), 1'b0, 1'b0, $sformatf("rand%0d_r%0d", i, r), n, n + 1, MAXR - n);
    end

    run_txn(4'd12, rand_state(), 1'b1, 1'b0, "start_while_busy", 12, 13, 0);
    run_txn(4'd12, rand_state(), 1'b0, 1'b1, "set_clr_collide", 12, 13, 0);

`ifdef ASCON_CTRL_ABORT_EN
    start_and_wait_rounds(4'd12, 4, "abort_mid");
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_mid busy", busy, 0);
    chk("abort_mid finished", fin, 0);
    chk("abort_mid intr kept", intr, 1);
    watch_no_update("abort_mid");
    start_and_wait_rounds(4'd3, 3, "abort_last");
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_last busy", busy, 0);
    chk("abort_last finished", fin, 0);
    watch_no_update("abort_last");
`endif

    run_txn(4'd2, rand_state(), 1'b0, 1'b0, "pre_reset", 2, 3, 10);
    start_and_wait_rounds(4'd12, 5, "reset_mid");
    rst_n = 1'b0;
    #1;
    chk_st("reset_mid state_o", state_out, '0);
    chk("reset_mid idx", idx, 0);
    chk("reset_mid round_en", round_en, 0);
    chk("reset_mid update", upd, 0);
    chk("reset_mid busy", busy, 0);
    chk("reset_mid finished", fin, 0);
    chk("reset_mid intr", intr, 0);
    @(negedge clk); rst_n = 1'b1;
    watch_no_update("reset_mid");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
